// File: rtl/shift_piso_pkg.sv
// Shared definitions for the parallel-in/serial-out shifter and its helpers.
package shift_piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/shift_piso_hold_reg.sv
// One-entry holding register: parks the next word while the current one
// is still being serialised, so words can follow each other with no gap.
module shift_hold_reg
  import shift_piso_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] hold,
  output logic             hold_full,
  output logic             din_ready
);

  // load is only possible while empty and drain only while full,
  // so the two never coincide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (load) begin
      hold      <= din;
      hold_full <= 1'b1;
    end else if (drain) begin
      hold_full <= 1'b0;
    end
  end

  assign din_ready = !hold_full;

endmodule

// File: rtl/shift_piso.sv
// Parallel-in/serial-out shifter: valid/ready word input, one bit per shift
// strobe on dout, with a holding register for back-to-back words.
module shift_piso
  import shift_piso_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             din_ready,
  input  logic             shift,
  output logic             dout,
  output logic             dout_valid,
  output logic             last,
  output logic             busy
);

  localparam int unsigned       CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_TOP = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   hold;
  logic [CNT_W-1:0]   cnt;
  logic               hold_full;
  logic               accept;
  logic               word_done;
  logic               load;
  logic               drain;

  assign accept    = din_valid && din_ready;
  assign word_done = (state == ST_SHIFT) && shift && (cnt == '0);
  // A word arriving exactly as the last bit leaves goes straight to shreg
  assign load      = accept && (state == ST_SHIFT) && !word_done;
  assign drain     = word_done && hold_full;

  shift_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .drain     (drain),
    .din       (din),
    .hold      (hold),
    .hold_full (hold_full),
    .din_ready (din_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg <= din;
            cnt   <= CNT_TOP;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (shift) begin
            if (cnt != '0) begin
              shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
              cnt   <= cnt - CNT_W'(1);
            end else if (hold_full) begin
              shreg <= hold;
              cnt   <= CNT_TOP;
            end else if (accept) begin
              shreg <= din;
              cnt   <= CNT_TOP;
            end else begin
              shreg <= '0;
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dout_valid = (state == ST_SHIFT);
  assign dout       = dout_valid && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  assign last       = dout_valid && (cnt == '0);
  assign busy       = dout_valid || hold_full;

endmodule

// File: tb/tb_shift_piso.sv
// Randomised scoreboard bench for shift_piso: MSB-first and LSB-first
// instances share stimulus and are checked against a bit-queue model.
module tb_shift_piso;

  localparam int unsigned W = 8;

  typedef struct {
    logic         b;
    logic         lst;
    logic [W-1:0] word;
  } bit_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         din_valid = 1'b0;
  logic [W-1:0] din = '0;
  logic         shift = 1'b0;

  logic din_ready_m, dout_m, dout_valid_m, last_m, busy_m;
  logic din_ready_l, dout_l, dout_valid_l, last_l, busy_l;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned shift_mode = 0; // 0: always, 1: random, 2: pattern 1,0,0
  int unsigned step_no = 0;

  bit_t qm[$];
  bit_t ql[$];
  logic [W-1:0] recv_m = '0;
  logic [W-1:0] recv_l = '0;

  shift_piso #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .din_ready(din_ready_m),
    .shift(shift), .dout(dout_m), .dout_valid(dout_valid_m), .last(last_m), .busy(busy_m)
  );

  shift_piso #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .din_ready(din_ready_l),
    .shift(shift), .dout(dout_l), .dout_valid(dout_valid_l), .last(last_l), .busy(busy_l)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // Reference: every accepted word becomes WIDTH bits in transmit order
  task automatic push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) qm.push_back('{b: w[i], lst: (i == 0), word: w});
    for (int i = 0; i < W; i++)      ql.push_back('{b: w[i], lst: (i == W - 1), word: w});
  endtask

  task automatic step(output bit accepted);
    bit acc;
    @(negedge clk);
    acc = din_valid && din_ready_m && !rst;
    @(posedge clk);
    if (acc) push_word(din);
    #1;
    step_no++;
    case (shift_mode)
      0:       shift = 1'b1;
      1:       shift = 1'($urandom_range(0, 1));
      default: shift = (step_no % 3 == 0);
    endcase
    accepted = acc;
  endtask

  task automatic idle_steps(input int unsigned n);
    bit a;
    for (int unsigned i = 0; i < n; i++) step(a);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    bit a;
    din_valid = 1'b1;
    din = w;
    a = 1'b0;
    for (int i = 0; i < 200 && !a; i++) step(a);
    if (!a) chk("accept_timeout", 8'h00, 8'h01);
    din_valid = 1'b0;
    din = $urandom;
  endtask

  task automatic drain_all();
    bit a;
    shift_mode = 0;
    for (int i = 0; i < 1000 && qm.size() != 0; i++) step(a);
    if (qm.size() != 0) chk("drain_timeout", 8'(qm.size()), 8'h00);
    step(a);
  endtask

  // Monitor: occupancy of the bit queue defines valid/ready/busy; consumed
  // bits are popped and reassembled like a receiving SIPO would
  always @(negedge clk) begin
    if (!rst) begin
      chk("dout_valid", 8'(dout_valid_m), 8'(qm.size() != 0));
      chk("dout_valid_lsb", 8'(dout_valid_l), 8'(ql.size() != 0));
      chk("din_ready", 8'(din_ready_m), 8'(qm.size() <= W));
      chk("busy", 8'(busy_m), 8'(qm.size() != 0));
      if (qm.size() != 0 && ql.size() != 0) begin
        chk("dout", 8'(dout_m), 8'(qm[0].b));
        chk("last", 8'(last_m), 8'(qm[0].lst));
        chk("dout_lsb", 8'(dout_l), 8'(ql[0].b));
        chk("last_lsb", 8'(last_l), 8'(ql[0].lst));
        if (shift) begin
          recv_m = {recv_m[W-2:0], dout_m};
          recv_l = {dout_l, recv_l[W-1:1]};
          if (qm[0].lst) chk("sipo_word", recv_m, qm[0].word);
          if (ql[0].lst) chk("sipo_word_lsb", recv_l, ql[0].word);
          void'(qm.pop_front());
          void'(ql.pop_front());
        end
      end else begin
        chk("idle_dout", 8'({dout_m, dout_l, last_m, last_l}), 8'h00);
      end
    end
  end

  initial begin
    // Reset with a word on the input
    din_valid = 1'b1;
    din = 8'hFF;
    shift = 1'b1;
    #1;
    chk("rst_outputs", 8'({dout_m, dout_valid_m, busy_m, dout_valid_l}), 8'h00);
    chk("rst_din_ready", 8'(din_ready_m), 8'h01);
    idle_steps(3);
    chk("rst_held_outputs", 8'({dout_m, dout_valid_m, last_m, busy_m}), 8'h00);
    din_valid = 1'b0;
    rst = 1'b0;
    idle_steps(3);

    // Single word, continuous strobes
    send_word(8'hA5);
    drain_all();

    // Back-to-back words
    send_word(8'hC3);
    send_word(8'h5A);
    chk("ready_low_after_2nd", 8'(din_ready_m), 8'h00);
    drain_all();

    // Stalled strobes
    shift_mode = 2;
    send_word(8'h81);
    shift_mode = 2;
    for (int i = 0; i < 100 && qm.size() != 0; i++) idle_steps(1);
    chk("stall_drained", 8'(qm.size()), 8'h00);
    idle_steps(2);

    // Loopback words, LSB instance checked in parallel
    shift_mode = 0;
    send_word(8'h3C);
    drain_all();

    // Mid-word reset with the holding register full
    send_word(8'hF0);
    send_word(8'h77);
    idle_steps(2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", 8'({dout_m, dout_valid_m, last_m, busy_m, dout_valid_l, busy_l}), 8'h00);
    chk("async_rst_ready", 8'({din_ready_m, din_ready_l}), 8'h03);
    qm.delete();
    ql.delete();
    idle_steps(1);
    rst = 1'b0;
    idle_steps(1);
    send_word(8'h0F);
    drain_all();

    // Random traffic with random strobes and producer gaps
    shift_mode = 1;
    for (int n = 0; n < 60; n++) begin
      send_word(8'($urandom));
      shift_mode = 1;
      idle_steps($urandom_range(0, 3));
    end
    drain_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
